// File: rtl/dino_jump_ctrl_if.sv
// Groups the per-channel jump controls and sprite outputs of dino_jump_ctrl.
// The master drives step, freeze and jump_req; the slave returns positions and event pulses.
interface dino_jump_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int Y_W    = 9
);
  logic                    step;
  logic                    freeze;
  logic [NUM_CH-1:0]       jump_req;
  logic [NUM_CH*Y_W-1:0]   y_pos;
  logic [NUM_CH-1:0]       airborne;
  logic [NUM_CH-1:0]       leg;
  logic [NUM_CH-1:0]       jump_ack;
  logic [NUM_CH-1:0]       landed;

  modport master (
    output step, freeze, jump_req,
    input  y_pos, airborne, leg, jump_ack, landed
  );

  modport slave (
    input  step, freeze, jump_req,
    output y_pos, airborne, leg, jump_ack, landed
  );
endinterface

// File: rtl/dino_jump_ctrl.sv
// Per-channel ground/air jump physics with leg animation; every output is registered (1 cycle latency).
// No backpressure: freeze holds all state, and requests arriving while airborne are dropped.
module dino_jump_ctrl #(
  parameter int                    NUM_CH    = 2,
  parameter int                    Y_W       = 9,
  parameter logic [NUM_CH*Y_W-1:0] GROUND_Y  = {9'd386, 9'd146},
  parameter int                    V1        = 6,
  parameter int                    V2        = 4,
  parameter int                    V3        = 2,
  parameter int                    N1        = 10,
  parameter int                    N2        = 10,
  parameter int                    N3        = 12,
  parameter int                    LEG_STEPS = 8
) (
  input  logic          clk,
  input  logic          rst,
  dino_jump_ctrl_if.slave bus
);

  localparam int H  = N1 + N2 + N3;
  localparam int T  = 2 * H;
  localparam int KW = $clog2(T + 1);
  localparam int LW = (LEG_STEPS > 1) ? $clog2(LEG_STEPS) : 1;

  // Segment boundaries on the step counter; the descent mirrors the ascent.
  localparam logic [KW-1:0] K_S1   = KW'(N1);
  localparam logic [KW-1:0] K_S2   = KW'(N1 + N2);
  localparam logic [KW-1:0] K_APEX = KW'(H);
  localparam logic [KW-1:0] K_S4   = KW'(H + N3);
  localparam logic [KW-1:0] K_S5   = KW'(H + N3 + N2);
  localparam logic [KW-1:0] K_LAND = KW'(T - 1);

  localparam logic [Y_W-1:0] V1_Y = Y_W'(V1);
  localparam logic [Y_W-1:0] V2_Y = Y_W'(V2);
  localparam logic [Y_W-1:0] V3_Y = Y_W'(V3);

  localparam logic [LW-1:0] LEG_MAX = LW'(LEG_STEPS - 1);

  typedef enum logic {
    GROUND = 1'b0,
    AIR    = 1'b1
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [Y_W-1:0] Y_GND    = GROUND_Y[i*Y_W +: Y_W];
    localparam logic           LEG_INIT = ((i % 2) == 1);

    state_t          st;
    logic [KW-1:0]   k;
    logic [Y_W-1:0]  y;
    logic [LW-1:0]   leg_cnt;
    logic            leg_q;
    logic            ack_q;
    logic            land_q;
    logic [Y_W-1:0]  vel;
    logic            rising;

    always_comb begin
      vel    = V1_Y;
      rising = 1'b1;
      if (k < K_S1) begin
        vel = V1_Y;
      end else if (k < K_S2) begin
        vel = V2_Y;
      end else if (k < K_APEX) begin
        vel = V3_Y;
      end else begin
        rising = 1'b0;
        if (k < K_S4)      vel = V3_Y;
        else if (k < K_S5) vel = V2_Y;
        else               vel = V1_Y;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st      <= GROUND;
        k       <= '0;
        y       <= Y_GND;
        leg_cnt <= '0;
        leg_q   <= LEG_INIT;
        ack_q   <= 1'b0;
        land_q  <= 1'b0;
      end else begin
        ack_q  <= 1'b0;
        land_q <= 1'b0;
        if (!bus.freeze) begin
          case (st)
            GROUND: begin
              // An accepted request swallows a coincident step: no motion, no leg count.
              if (bus.jump_req[i]) begin
                st    <= AIR;
                k     <= '0;
                ack_q <= 1'b1;
              end else if (bus.step) begin
                if (leg_cnt == LEG_MAX) begin
                  leg_cnt <= '0;
                  leg_q   <= ~leg_q;
                end else begin
                  leg_cnt <= leg_cnt + 1'b1;
                end
              end
            end
            AIR: begin
              if (bus.step) begin
                if (k == K_LAND) begin
                  st     <= GROUND;
                  k      <= '0;
                  y      <= Y_GND;
                  land_q <= 1'b1;
                end else begin
                  k <= k + 1'b1;
                  y <= rising ? (y - vel) : (y + vel);
                end
              end
            end
            default: st <= GROUND;
          endcase
        end
      end
    end

    assign bus.y_pos[i*Y_W +: Y_W] = y;
    assign bus.airborne[i]         = (st == AIR);
    assign bus.leg[i]              = leg_q;
    assign bus.jump_ack[i]         = ack_q;
    assign bus.landed[i]           = land_q;
  end

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Scenario bench for dino_jump_ctrl: trajectory expectations are queued as steps are driven.
module tb_dino_jump_ctrl;
  localparam int NUM_CH = 2;
  localparam int Y_W    = 9;
  localparam int H      = 32;
  localparam int T      = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dino_jump_ctrl_if #(.NUM_CH(NUM_CH), .Y_W(Y_W)) bus ();

  dino_jump_ctrl #(.NUM_CH(NUM_CH), .Y_W(Y_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [Y_W-1:0] yv [NUM_CH];
  assign yv[0] = bus.y_pos[8:0];
  assign yv[1] = bus.y_pos[17:9];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int             ch;
    int             n;
    logic [Y_W-1:0] y;
  } exp_t;
  exp_t sb[$];

  function automatic logic [Y_W-1:0] gnd(int ch);
    return (ch == 0) ? 9'd146 : 9'd386;
  endfunction

  // Height above ground after n steps, as a closed-form sum of full segments.
  function automatic int height(int n);
    int m, d;
    m = (n > H) ? (T - n) : n;
    d = 0;
    d += 6 * ((m < 10) ? m : 10);
    if (m > 10) d += 4 * ((m - 10 < 10) ? (m - 10) : 10);
    if (m > 20) d += 2 * (m - 20);
    return d;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_step(input int n, input logic [1:0] air);
    exp_t e;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e.ch = ch;
      e.n  = n;
      e.y  = air[ch] ? (gnd(ch) - 9'(height(n))) : gnd(ch);
      sb.push_back(e);
    end
    bus.step = 1'b1;
    cycle();
    bus.step = 1'b0;
  endtask

  task automatic start_jump(input logic [1:0] req);
    bus.jump_req = req;
    cycle();
    bus.jump_req = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    total++; if (yv[0] !== 9'd146) begin bad++; $display("FAIL reset_y0 got=%0d want=146", yv[0]); end
    total++; if (yv[1] !== 9'd386) begin bad++; $display("FAIL reset_y1 got=%0d want=386", yv[1]); end
    total++; if (bus.airborne !== 2'b00) begin bad++; $display("FAIL reset_air got=%b want=00", bus.airborne); end
    total++; if (bus.leg !== 2'b10) begin bad++; $display("FAIL reset_leg got=%b want=10", bus.leg); end
    total++; if ({bus.jump_ack, bus.landed} !== 4'b0000) begin bad++; $display("FAIL reset_pulses got=%b want=0000", {bus.jump_ack, bus.landed}); end
  endtask

  task automatic test_full_jump();
    exp_t e;
    start_jump(2'b01);
    total++; if (bus.jump_ack !== 2'b01 || bus.airborne !== 2'b01) begin bad++; $display("FAIL fj_accept ack=%b air=%b want 01/01", bus.jump_ack, bus.airborne); end
    cycle();
    total++; if (bus.jump_ack !== 2'b00) begin bad++; $display("FAIL fj_ack_pulse got=%b want=00", bus.jump_ack); end
    for (int n = 1; n <= T; n++) begin
      drive_step(n, 2'b01);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++; if (yv[e.ch] !== e.y) begin bad++; $display("FAIL fj_traj ch%0d step%0d got=%0d want=%0d", e.ch, e.n, yv[e.ch], e.y); end
      end
      total++; if (bus.landed !== ((n == T) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL fj_landed step%0d got=%b", n, bus.landed); end
      if (n == 32) begin
        total++; if (yv[0] !== 9'd22) begin bad++; $display("FAIL fj_apex got=%0d want=22", yv[0]); end
      end
    end
    total++; if (bus.airborne !== 2'b00) begin bad++; $display("FAIL fj_ground got=%b want=00", bus.airborne); end
    cycle();
    total++; if (bus.landed !== 2'b00) begin bad++; $display("FAIL fj_landed_once got=%b want=00", bus.landed); end
  endtask

  task automatic test_retrigger();
    exp_t e;
    start_jump(2'b01);
    for (int n = 1; n <= T; n++) begin
      drive_step(n, 2'b01);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++; if (yv[e.ch] !== e.y) begin bad++; $display("FAIL rt_traj ch%0d step%0d got=%0d want=%0d", e.ch, e.n, yv[e.ch], e.y); end
      end
      if (n == 5) begin
        start_jump(2'b01);
        total++; if (bus.jump_ack !== 2'b00 || bus.airborne !== 2'b01) begin bad++; $display("FAIL rt_ignored ack=%b air=%b want 00/01", bus.jump_ack, bus.airborne); end
      end
      if (n == 10) begin
        total++; if (yv[0] !== 9'd86) begin bad++; $display("FAIL rt_step10 got=%0d want=86", yv[0]); end
      end
    end
    total++; if (bus.landed !== 2'b01 || bus.airborne !== 2'b00) begin bad++; $display("FAIL rt_land landed=%b air=%b want 01/00", bus.landed, bus.airborne); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    bus.jump_req = 2'b11;
    bus.step     = 1'b1;
    cycle();
    bus.jump_req = 2'b00;
    bus.step     = 1'b0;
    total++; if (bus.jump_ack !== 2'b11) begin bad++; $display("FAIL sim_ack got=%b want=11", bus.jump_ack); end
    total++; if (yv[0] !== 9'd146 || yv[1] !== 9'd386) begin bad++; $display("FAIL sim_nomove y0=%0d y1=%0d want 146/386", yv[0], yv[1]); end
    for (int n = 1; n <= T; n++) begin
      drive_step(n, 2'b11);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++; if (yv[e.ch] !== e.y) begin bad++; $display("FAIL sim_traj ch%0d step%0d got=%0d want=%0d", e.ch, e.n, yv[e.ch], e.y); end
      end
      if (n == 32) begin
        total++; if (yv[0] !== 9'd22 || yv[1] !== 9'd262) begin bad++; $display("FAIL sim_apex y0=%0d y1=%0d want 22/262", yv[0], yv[1]); end
      end
      total++; if (bus.landed !== ((n == T) ? 2'b11 : 2'b00)) begin bad++; $display("FAIL sim_landed step%0d got=%b", n, bus.landed); end
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    logic [1:0] leg_hold;
    int         hold_bad;
    start_jump(2'b01);
    for (int n = 1; n <= 20; n++) begin
      drive_step(n, 2'b01);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++; if (yv[e.ch] !== e.y) begin bad++; $display("FAIL fz_traj ch%0d step%0d got=%0d want=%0d", e.ch, e.n, yv[e.ch], e.y); end
      end
    end
    total++; if (yv[0] !== 9'd46) begin bad++; $display("FAIL fz_step20 got=%0d want=46", yv[0]); end
    leg_hold = bus.leg;
    bus.freeze = 1'b1;
    hold_bad = 0;
    for (int c = 0; c < 100; c++) begin
      bus.step     = 1'b1;
      bus.jump_req = (c % 3 == 0) ? 2'b11 : 2'b00;
      cycle();
      if (yv[0] !== 9'd46 || yv[1] !== 9'd386 || bus.airborne !== 2'b01 || bus.leg !== leg_hold ||
          bus.jump_ack !== 2'b00 || bus.landed !== 2'b00) hold_bad++;
    end
    bus.step     = 1'b0;
    bus.jump_req = 2'b00;
    bus.freeze   = 1'b0;
    total++; if (hold_bad != 0) begin bad++; $display("FAIL fz_hold cycles_wrong=%0d want=0 (y0=%0d leg=%b)", hold_bad, yv[0], bus.leg); end
    for (int n = 21; n <= T; n++) begin
      drive_step(n, 2'b01);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++; if (yv[e.ch] !== e.y) begin bad++; $display("FAIL fz_resume ch%0d step%0d got=%0d want=%0d", e.ch, e.n, yv[e.ch], e.y); end
      end
      if (n == 32) begin
        total++; if (yv[0] !== 9'd22) begin bad++; $display("FAIL fz_apex got=%0d want=22", yv[0]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    start_jump(2'b01);
    for (int n = 1; n < T; n++) begin
      drive_step(n, 2'b01);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++; if (yv[e.ch] !== e.y) begin bad++; $display("FAIL bb_traj ch%0d step%0d got=%0d want=%0d", e.ch, e.n, yv[e.ch], e.y); end
      end
    end
    bus.jump_req = 2'b01;
    drive_step(T, 2'b01);
    bus.jump_req = 2'b00;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (yv[e.ch] !== e.y) begin bad++; $display("FAIL bb_touch ch%0d got=%0d want=%0d", e.ch, yv[e.ch], e.y); end
    end
    total++; if (bus.landed !== 2'b01 || bus.jump_ack !== 2'b00 || bus.airborne !== 2'b00) begin bad++; $display("FAIL bb_touch_req landed=%b ack=%b air=%b want 01/00/00", bus.landed, bus.jump_ack, bus.airborne); end
    start_jump(2'b01);
    total++; if (bus.jump_ack !== 2'b01 || bus.airborne !== 2'b01) begin bad++; $display("FAIL bb_next_req ack=%b air=%b want 01/01", bus.jump_ack, bus.airborne); end
    drive_step(1, 2'b01);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (yv[e.ch] !== e.y) begin bad++; $display("FAIL bb_rejump ch%0d got=%0d want=%0d", e.ch, yv[e.ch], e.y); end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    start_jump(2'b01);
    for (int n = 1; n <= 15; n++) begin
      bus.step = 1'b1;
      cycle();
      bus.step = 1'b0;
    end
    total++; if (yv[0] !== 9'(146 - height(15))) begin bad++; $display("FAIL rm_step15 got=%0d want=%0d", yv[0], 146 - height(15)); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    total++; if (yv[0] !== 9'd146 || bus.airborne !== 2'b00 || bus.landed !== 2'b00) begin bad++; $display("FAIL rm_abort y0=%0d air=%b landed=%b want 146/00/00", yv[0], bus.airborne, bus.landed); end
    cycle();
    total++; if (bus.landed !== 2'b00) begin bad++; $display("FAIL rm_no_land got=%b want=00", bus.landed); end
    for (int n = 1; n <= 7; n++) begin
      bus.step = 1'b1;
      cycle();
      bus.step = 1'b0;
    end
    total++; if (bus.leg !== 2'b10) begin bad++; $display("FAIL rm_leg7 got=%b want=10", bus.leg); end
    bus.step = 1'b1;
    cycle();
    bus.step = 1'b0;
    total++; if (bus.leg !== 2'b01) begin bad++; $display("FAIL rm_leg8 got=%b want=01", bus.leg); end
  endtask

  initial begin
    rst          = 1'b1;
    bus.step     = 1'b0;
    bus.freeze   = 1'b0;
    bus.jump_req = 2'b00;
    test_reset();
    test_full_jump();
    test_retrigger();
    test_simultaneous();
    test_freeze();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dino_jump_ctrl.md
# dino_jump_ctrl

Multi-channel jump-physics engine for the Dino game. One channel per player sprite. Each channel runs an independent ground/airborne state machine that turns one-cycle jump requests (from the keypad and PS/2 decoders) into a symmetric, piecewise-constant-velocity vertical trajectory, advanced on a shared motion strobe. It also supplies the running-leg animation bit. The block sits between the input decoders and the sprite renderer, which consumes `y_pos` and `leg`.

## Interface
Parameters:
- `NUM_CH`, 2: number of independent sprite channels.
- `Y_W`, 9: width of each Y coordinate (matches `row_addr`).
- `GROUND_Y`, {9'd386, 9'd146}: packed `NUM_CH*Y_W` ground rows. Channel *i* is in bits `[i*Y_W +: Y_W]`.
- `V1`, `V2`, `V3`, 6 / 4 / 2: rows moved per step in segments 1..3.
- `N1`, `N2`, `N3`, 10 / 10 / 12: steps spent in segments 1..3.
- `LEG_STEPS`, 8: ground steps between leg toggles.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `step`  in  1  one-cycle motion strobe (one physics step).
- `freeze`  in  1  level; while high, all channel state holds (game over / pause).
- `jump_req`  in  NUM_CH  one-cycle jump request per channel.
- `y_pos`  out  NUM_CH*Y_W  sprite top-left row per channel.
- `airborne`  out  NUM_CH  1 = channel is in a jump.
- `leg`  out  NUM_CH  leg-frame select (0 = DinoL, 1 = DinoR).
- `jump_ack`  out  NUM_CH  one-cycle pulse when a request is accepted.
- `landed`  out  NUM_CH  one-cycle pulse on touchdown.

## Operation
- Derived values: H = N1+N2+N3 (rise steps); T = 2H (total steps). The per-channel step counter `k` has width $clog2(T+1).
- Per-channel FSM states are GROUND and AIR.
  - GROUND → AIR when `jump_req[i]` is high and `freeze` is low. On that transition `k` is set to 0 and `jump_ack[i]` pulses.
  - AIR → GROUND on the step where k = T−1. That step forces `y` to exactly GROUND_Y[i] and pulses `landed[i]`.
- Velocity per step in AIR, chosen by the current k:
  - k < N1: y −= V1.
  - k < N1+N2: y −= V2.
  - k < H: y −= V3.
  - k < H+N3: y += V3.
  - k < H+N3+N2: y += V2.
  - otherwise: y += V1.
  - k increments after each step.
- Arithmetic is unsigned Y_W-bit. Configuration constraint: V1·N1+V2·N2+V3·N3 ≤ every GROUND_Y[i]. The RTL does not check this; behaviour is undefined if it is violated.
- `jump_req` while in AIR is ignored: no ack, no restart. There is no double jump.
- Leg animation:
  - A per-channel counter counts `step` strobes in GROUND with `freeze` low.
  - On reaching LEG_STEPS−1 the counter wraps to 0 and `leg[i]` toggles.
  - In AIR, both the counter and `leg` hold.
- `freeze` high:
  - `step` and `jump_req` are ignored.
  - `y_pos`, `k`, `airborne`, `leg` and the leg counters hold.
  - No ack or landed pulses are produced.
- Channels are fully independent. Any combination of simultaneous requests and landings is legal.

## Timing
- Reset values (on the cycle after `rst` sampled high):
  - `y_pos[i]` = GROUND_Y[i].
  - `airborne` = 0; `jump_ack` = 0; `landed` = 0.
  - `leg[i]` = i[0], so even channels start at 0 and odd channels at 1 (anti-phase).
  - All counters = 0.
- `rst` takes priority over every input and aborts a jump mid-air. It produces no `landed` pulse.
- Request latency: with `jump_req[i]` high in cycle n, `airborne[i]` and `jump_ack[i]` are high in cycle n+1.
- If `step` coincides with an accepted `jump_req`, there is no movement that cycle. The first displacement happens on the next `step`.
- A `step` in cycle n updates `y_pos` and `k` visible in cycle n+1 (registered, latency 1).
- Touchdown: `landed[i]` is high for exactly the one cycle in which `y_pos` first equals GROUND_Y[i] and `airborne[i]` falls.
- A `jump_req[i]` in that same touchdown-update cycle (the channel still reads AIR) is ignored. A request one cycle later is accepted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then observe with no stimulus → y0 = 146, y1 = 386, airborne = 00, leg = 2'b10, no pulses.
- Full jump on channel 0: pulse `jump_req[0]`, then 64 `step` strobes →
  - y0 after step 10 = 86, after step 20 = 46, after step 32 = 22 (apex), after step 64 = 146.
  - `landed[0]` pulses once; ch1 stays at 386.
- Re-trigger: `jump_req[0]` at step 5 of a jump → no `jump_ack`. The jump still lands after exactly 64 total steps; y0 at step 10 = 86.
- Simultaneous start: `jump_req` = 2'b11 in the same cycle as `step` → both acks pulse, y unchanged that cycle. After 32 further steps, y0 = 22 and y1 = 262. Both `landed` pulses fire in the same cycle.
- Freeze mid-air at step 20 (y0 = 46) for 100 strobes → y0, leg and airborne hold, no pulses. Release, then 12 steps → y0 = 22.
- Reset mid-jump at step 15 → next cycle y0 = 146, airborne[0] = 0, no `landed`. On the ground, 8 steps → leg[0] toggles 0→1 and leg[1] toggles 1→0.
